// File: rtl/exc_collect.sv
// Exception collector and MEM-stage exception register.
// Holds the MEM-stage copy of each instruction's exception flags, checks
// data-address alignment, samples pending interrupts, and presents the single
// highest-priority exception (code, PC, delay-slot bit, bad address) to cp0.
module exc_collect #(
    parameter logic [4:0] EXC_NONE = 5'h10,
    parameter logic [4:0] EXC_ERET = 5'h11
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        ex_valid_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ex_is_branch_i,
    input  logic [5:0]  ex_exc_i,
    input  logic        ex_is_load_i,
    input  logic        ex_is_store_i,
    input  logic [1:0]  ex_size_i,
    input  logic [31:0] ex_maddr_i,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    output logic [4:0]  exccode_o,
    output logic [31:0] pc_o,
    output logic        in_delay_o,
    output logic [31:0] badvaddr_o,
    output logic        mem_kill_o
);

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // MEM register fields
    logic        valid;
    logic [31:0] pc;
    logic        is_branch;
    logic [5:0]  exc;
    logic        is_load;
    logic        is_store;
    logic [1:0]  size;
    logic [31:0] maddr;
    logic        prev_br;
    logic        lockout;

    // Flag bit positions within exc: {fetch_adel, ri, sys, bp, ov, eret}
    logic fetch_adel, ri, sys, bp, ov, eret;
    assign fetch_adel = exc[5];
    assign ri         = exc[4];
    assign sys        = exc[3];
    assign bp         = exc[2];
    assign ov         = exc[1];
    assign eret       = exc[0];

    logic misaligned;
    logic data_adel;
    logic data_ades;
    logic int_p;

    assign misaligned = ((size == SIZE_HALF) && maddr[0]) ||
                        ((size == SIZE_WORD) && (maddr[1:0] != 2'b00));
    assign data_adel  = is_load  && misaligned;
    assign data_ades  = is_store && misaligned;
    assign int_p      = status_i[0] && !status_i[1] &&
                        (|(status_i[15:8] & cause_i[15:8]));

    // MEM register load: flush squashes, stall holds, otherwise take EX
    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            valid     <= 1'b0;
            pc        <= '0;
            is_branch <= 1'b0;
            exc       <= '0;
            is_load   <= 1'b0;
            is_store  <= 1'b0;
            size      <= '0;
            maddr     <= '0;
            prev_br   <= 1'b0;
            lockout   <= 1'b0;
        end else begin
            lockout <= flush_i;
            if (flush_i) begin
                valid   <= 1'b0;
                prev_br <= 1'b0;
            end else if (!stall_i) begin
                // prev_br tracks the last valid instruction that left MEM,
                // so a bubble between branch and delay slot keeps the flag
                if (valid) begin
                    prev_br <= is_branch;
                end
                valid     <= ex_valid_i;
                pc        <= ex_pc_i;
                is_branch <= ex_is_branch_i;
                exc       <= ex_exc_i;
                is_load   <= ex_is_load_i;
                is_store  <= ex_is_store_i;
                size      <= ex_size_i;
                maddr     <= ex_maddr_i;
            end
        end
    end

    // Priority select of the single exception and its bad address
    always_comb begin
        exccode_o  = EXC_NONE;
        badvaddr_o = '0;
        if (valid && !lockout) begin
            if (int_p) begin
                exccode_o = EXC_INT;
            end else if (fetch_adel) begin
                exccode_o  = EXC_ADEL;
                badvaddr_o = pc;
            end else if (ri) begin
                exccode_o = EXC_RI;
            end else if (sys) begin
                exccode_o = EXC_SYS;
            end else if (bp) begin
                exccode_o = EXC_BP;
            end else if (ov) begin
                exccode_o = EXC_OV;
            end else if (data_adel) begin
                exccode_o  = EXC_ADEL;
                badvaddr_o = maddr;
            end else if (data_ades) begin
                exccode_o  = EXC_ADES;
                badvaddr_o = maddr;
            end else if (eret) begin
                exccode_o = EXC_ERET;
            end
        end
    end

    assign pc_o       = pc;
    assign in_delay_o = valid && prev_br;
    assign mem_kill_o = (exccode_o != EXC_NONE);

endmodule

// File: doc/exc_collect.md
# exc_collect

Exception collector and MEM-stage exception register for the MIPS pipeline. Latches each instruction's exception flags from EX, checks data-address alignment, samples pending interrupts from CP0 status/cause, and selects the single highest-priority exception. It drives the exception code, PC, delay-slot bit and bad address into cp0_reg, and consumes cp0_reg's flush to squash its own stage.

## Interface
Parameters:
- EXC_NONE, 5'h10, code meaning no exception
- EXC_ERET, 5'h11, code for ERET
- MIPS codes (fixed): INT 5'h00, ADEL 5'h04, ADES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c

Ports:
- cpu_clk_50M  in  1  clock; one clock domain
- cpu_rst_n  in  1  reset, asynchronous, active-low
- stall_i  in  1  hold the MEM exception register
- flush_i  in  1  flush from cp0_reg; squash the stage
- ex_valid_i  in  1  EX carries a real instruction (0 = bubble)
- ex_pc_i  in  32  PC of the EX instruction
- ex_is_branch_i  in  1  EX instruction is a branch or jump
- ex_exc_i  in  6  flags {fetch_adel, ri, sys, bp, ov, eret}
- ex_is_load_i, ex_is_store_i  in  1 each  memory-access type
- ex_size_i  in  2  access size: 0 byte, 1 half, 2 word
- ex_maddr_i  in  32  effective data address
- status_i, cause_i  in  32 each  CP0 status and cause
- exccode_o  out  5  to cp0 exccode_i
- pc_o  out  32  to cp0 pc_i
- in_delay_o  out  1  to cp0 in_delay_i
- badvaddr_o  out  32  to cp0 badvaddr_i
- mem_kill_o  out  1  suppress memory write and regfile write of the MEM instruction

## Operation
- MEM register fields: valid, pc, is_branch, exc[5:0], is_load, is_store, size, maddr.
- Register load rules:
  - flush_i = 1 clears valid.
  - Otherwise stall_i = 1 holds all fields.
  - Otherwise the register loads all EX inputs.
- Delay-slot flag prev_br:
  - When a valid MEM instruction advances (valid & !stall_i & !flush_i), prev_br takes that instruction's is_branch.
  - prev_br clears on flush.
  - in_delay_o = valid & prev_br.
- Data misalignment: half access with maddr[0] set; word access with maddr[1:0] nonzero. Misaligned load gives ADEL; misaligned store gives ADES.
- Interrupt pending: int_p = status[0] & ~status[1] & |(status[15:8] & cause[15:8]). An interrupt attaches only to a valid MEM instruction.
- Priority, highest first, for a valid instruction: INT, fetch ADEL, RI, SYS, BP, OV, data ADEL/ADES, ERET, otherwise EXC_NONE.
- A bubble (valid = 0) always yields EXC_NONE.
- pc_o = pc. cp0 applies the −4 adjustment for delay slots.
- badvaddr_o: pc for fetch ADEL; maddr for data ADEL/ADES; 0 otherwise.
- mem_kill_o = 1 whenever exccode_o ≠ EXC_NONE, including ERET.
- Lockout: for the cycle after flush_i, exccode_o is forced to EXC_NONE. This matches cp0's one-cycle flush_im.

## Timing
- Reset (asynchronous): valid = 0, prev_br = 0, lockout = 0, all fields 0.
  - Outputs during reset: exccode_o = EXC_NONE, pc_o = 0, badvaddr_o = 0, in_delay_o = 0, mem_kill_o = 0.
- EX to MEM latency is one cycle. All outputs are combinational from the MEM register, status_i and cause_i.
- An exception is presented in the same cycle the instruction sits in MEM. cp0 asserts flush_i combinationally in that cycle.
- Reset released while an exception is presented: nothing is retained; the first cycle after reset release shows EXC_NONE.
- Stall with an exception present: the exception is still presented and flush_i wins over stall_i. Next cycle valid = 0.
- An interrupt arriving during a stall is taken on the held instruction.
- flush_i and a valid EX instruction in the same cycle: the EX instruction is discarded.

## Test plan
- Reset, then a single valid instruction (pc 0xBFC0_0100, no flags):
  - exccode_o stays 5'h10 and mem_kill_o = 0.
- Load, size 2, maddr 0x8000_0002:
  - One cycle later: exccode_o = 5'h04 and badvaddr_o = 0x8000_0002.
  - After flush_i, the next cycle is EXC_NONE.
- Branch at 0x100, then an instruction at 0x104 with sys set:
  - exccode_o = 5'h08, in_delay_o = 1, pc_o = 0x104.
- ri and ov both set, with status = 0x0000_0401 and cause[10] = 1:
  - exccode_o = 5'h00 (INT wins).
  - Same case with status[1] = 1: exccode_o = 5'h0a.
- stall_i held 3 cycles on a store, size 1, maddr 0x...1:
  - ADES is presented in the first cycle; flush_i squashes the instruction despite the stall.
- Bubble in MEM with an interrupt pending:
  - EXC_NONE; the interrupt is taken on the next valid instruction.
